// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the parametrised UART transmit FIFO.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } send_state_t;

  // Occupancy needs one bit more than the index so that 0..DEPTH all fit.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port character store: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo_p.sv
// UART transmit FIFO: edge-detected CPU pushes into a circular buffer, one-at-a-time
// hand-off to the transmitter, with level/full/almost-full/overflow status and flush.
module uart_tx_fifo_p
  import uart_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W       = 8,
  parameter  int unsigned DEPTH        = 512,
  parameter  int unsigned AFULL_THRESH = 448,
  localparam int unsigned ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       i_wr_data,
  input  logic              i_wr_start,
  output logic              o_clear_req,
  output logic              o_busy,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_start_clear,
  output logic [ADDR_W:0]   o_level,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_overflow,
  input  logic              i_ovf_clr
);

  localparam int unsigned LVL_W = level_w(DEPTH);

  send_state_t       state;
  logic [1:0]        wr_edge;
  logic [LVL_W-1:0]  wptr, rptr, wptr_n, rptr_n;
  logic [LVL_W-1:0]  level, level_n;
  logic              push_req, full_now, do_write, do_pop;
  logic [DATA_W-1:0] rdata;
  logic              wr_data_unused;

  assign wr_data_unused = ^i_wr_data;

  assign level    = wptr - rptr;
  assign push_req = (wr_edge == 2'b01);
  assign full_now = (level == LVL_W'(DEPTH));
  // Fullness is judged on the registered level, so a same-cycle pop never frees room for this push.
  assign do_write = push_req && !i_flush && !full_now;
  assign do_pop   = (state == LOAD) && !i_flush;

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    if (i_flush) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      if (do_write) wptr_n = wptr + 1'b1;
      if (do_pop)   rptr_n = rptr + 1'b1;
    end
  end

  assign level_n = wptr_n - rptr_n;

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (i_wr_data[DATA_W-1:0]),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_edge       <= '0;
      wptr          <= '0;
      rptr          <= '0;
      o_clear_req   <= 1'b0;
      o_busy        <= 1'b0;
      o_level       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      wr_edge       <= {wr_edge[0], i_wr_start};
      wptr          <= wptr_n;
      rptr          <= rptr_n;
      o_clear_req   <= push_req;
      o_busy        <= push_req;
      o_level       <= level_n;
      o_empty       <= (level_n == '0);
      o_full        <= (level_n == LVL_W'(DEPTH));
      o_almost_full <= (level_n >= LVL_W'(AFULL_THRESH));
      if (i_ovf_clr)
        o_overflow <= 1'b0;
      else if (push_req && !i_flush && full_now)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else if (i_flush) begin
      state      <= IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      case (state)
        IDLE: if (level != '0) state <= LOAD;
        LOAD: begin
          o_tx_data  <= rdata;
          o_tx_start <= 1'b1;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: if (i_tx_start_clear) begin
          o_tx_start <= 1'b0;
          o_tx_data  <= '0;
          state      <= (level != '0) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
